// File: rtl/timer_scheduler.sv
// timer_scheduler: one W-bit complement-load up-counter shared round-robin
// among NREQ requesters. The owner is granted, the counter is loaded with
// 2^W - len, and done pulses to the owner when the counter carries.
// Optional build macro TIMER_SCHED_TOGGLE_EN adds tick_out, which toggles
// on every completed delay. Cancels do not toggle it.
module timer_scheduler #(
  parameter int NREQ = 4,
  parameter int W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] len,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [W-1:0]      cnt_out
`ifdef TIMER_SCHED_TOGGLE_EN
  ,
  output logic              tick_out
`endif
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [W-1:0]      cnt_q, cnt_d;
  logic [IDXW-1:0]   ptr_q, ptr_d;
  logic [IDXW-1:0]   own_q, own_d;
  logic [W-1:0]      len_pick;
  int                pick_i;

  // The first requesting index at or after the pointer wins, wrapping around.
  // The scan runs from the farthest offset down to the nearest one, so the
  // nearest requester is the last match and overrides the others.
  function automatic int pick_next(input logic [NREQ-1:0] r, input int p);
    int res;
    res = p;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (r[(p + i) % NREQ]) res = (p + i) % NREQ;
    end
    return res;
  endfunction

  // Arbitration candidate and its delay, used only at the grant edge.
  always_comb begin
    pick_i   = pick_next(req, int'(ptr_q));
    len_pick = len[pick_i*W +: W];
  end

  // Next-state logic. A cancel takes priority over a carry in the same cycle.
  // A cancel leaves the counter at its current value.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (|req) begin
          own_d = IDXW'(pick_i);
          gnt_d = NREQ'(1) << pick_i;
          cnt_d = '0 - len_pick;
          if (len_pick == '0) begin
            state_d = DONE;
            done_d  = NREQ'(1) << pick_i;
          end else begin
            state_d = COUNT;
          end
        end
      end
      COUNT: begin
        if (!req[own_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = IDXW'((int'(own_q) + 1) % NREQ);
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '1) begin
            state_d = DONE;
            done_d  = gnt_q;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        ptr_d   = IDXW'((int'(own_q) + 1) % NREQ);
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      own_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign busy    = (state_q != IDLE);
  assign cnt_out = cnt_q;

`ifdef TIMER_SCHED_TOGGLE_EN
  logic tick_q, tick_d;

  // The square output flips whenever a done pulse is issued.
  always_comb begin
    tick_d = tick_q ^ (|done_d);
  end

  // Toggle register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_q <= 1'b0;
    else        tick_q <= tick_d;
  end

  assign tick_out = tick_q;
`endif

endmodule
